// File: rtl/fechadura_pkg.sv
// Shared types for the electronic lock: keypad packet format, controller states, packet classes.
package fechadura_pkg;

    localparam int unsigned NUM_NIB   = 20;
    localparam int unsigned CNT_DIG_W = 5;

    // digits[0] is the most recently typed digit; unused positions hold 4'hF
    typedef struct packed {
        logic [NUM_NIB-1:0][3:0] digits;
    } senhaPac_t;

    localparam senhaPac_t PAC_TIMEOUT   = senhaPac_t'({NUM_NIB{4'hE}});
    localparam senhaPac_t PAC_CANCEL    = senhaPac_t'({NUM_NIB{4'hB}});
    localparam senhaPac_t PAC_EMPTY     = senhaPac_t'({NUM_NIB{4'hF}});
    localparam senhaPac_t MASTER_PW_DEF = senhaPac_t'({{16{4'hF}}, 16'h9999});
    localparam senhaPac_t USER0_PW_DEF  = senhaPac_t'({{16{4'hF}}, 16'h1234});

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_OPEN,
        ST_LOCKOUT,
        ST_PROG_SLOT,
        ST_PROG_PASS
    } ctrl_state_t;

    typedef enum logic [1:0] {
        CL_DIGITS,
        CL_TIMEOUT,
        CL_CANCEL
    } pac_class_t;

    function automatic pac_class_t classifica(input senhaPac_t p);
        if (p == PAC_TIMEOUT) return CL_TIMEOUT;
        if (p == PAC_CANCEL)  return CL_CANCEL;
        return CL_DIGITS;
    endfunction

endpackage

// File: rtl/controlador_fechadura_if.sv
// Keypad-decoder / lock-controller bundle. FECHADURA_SENSOR_PORTA_EN adds the door sensor input.
interface controlador_fechadura_if;
    import fechadura_pkg::*;

    senhaPac_t   digitos_value;
    logic        digitos_valid;
    logic        teclado_en;
    logic        tranca;
    logic        bloqueado;
    logic        modo_prog;
    logic        erro;
    logic [3:0]  tentativas;
`ifdef FECHADURA_SENSOR_PORTA_EN
    logic        porta_aberta;
`endif

    modport master (
`ifdef FECHADURA_SENSOR_PORTA_EN
        output porta_aberta,
`endif
        output digitos_value,
        output digitos_valid,
        input  teclado_en,
        input  tranca,
        input  bloqueado,
        input  modo_prog,
        input  erro,
        input  tentativas
    );

    modport slave (
`ifdef FECHADURA_SENSOR_PORTA_EN
        input  porta_aberta,
`endif
        input  digitos_value,
        input  digitos_valid,
        output teclado_en,
        output tranca,
        output bloqueado,
        output modo_prog,
        output erro,
        output tentativas
    );

endinterface

// File: rtl/conta_digitos.sv
// Combinational count of typed (non-F) nibbles in a keypad packet.
module conta_digitos
    import fechadura_pkg::*;
(
    input  senhaPac_t              i_pac,
    output logic [CNT_DIG_W-1:0]   o_qtd_c
);

    always_comb begin
        o_qtd_c = '0;
        for (int i = 0; i < int'(NUM_NIB); i++) begin
            if (i_pac.digits[i] != 4'hF) o_qtd_c = o_qtd_c + CNT_DIG_W'(1);
        end
    end

endmodule

// File: rtl/controlador_fechadura.sv
// Lock sequencer: password check, bolt timing, lockout and master-gated slot programming.
// Optional door sensor: define FECHADURA_SENSOR_PORTA_EN.
module controlador_fechadura
    import fechadura_pkg::*;
#(
    parameter int unsigned NUM_USERS   = 4,
    parameter int unsigned MIN_DIGITS  = 4,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned UNLOCK_CYC  = 5000,
    parameter int unsigned LOCKOUT_CYC = 20000,
    parameter senhaPac_t   MASTER_PW   = MASTER_PW_DEF,
    parameter senhaPac_t   USER0_PW    = USER0_PW_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    controlador_fechadura_if.slave   bus
);

    localparam int unsigned MAX_CYC = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC);
    localparam int unsigned TRY_W   = $clog2(MAX_TRIES + 1);
    localparam int unsigned SLOT_W  = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1;

    ctrl_state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [TRY_W-1:0]      r_tent, w_tent_nxt;
    logic [SLOT_W-1:0]     r_slot_sel, w_slot_sel_nxt;
    senhaPac_t             r_pac;
    senhaPac_t             r_slots [NUM_USERS];

    logic                  r_teclado_en, r_tranca, r_bloqueado, r_modo_prog, r_erro;
    logic                  w_teclado_nxt, w_erro_nxt, w_flush, w_wr_en;

    senhaPac_t             w_pac;
    pac_class_t            w_cls;
    logic [CNT_DIG_W-1:0]  w_qtd;
    logic                  w_valid, w_curto, w_mestre, w_match, w_slot_ok;

`ifdef FECHADURA_SENSOR_PORTA_EN
    logic                  r_porta_vista, r_fecha_pend;
`endif

    // Keypad strobes are ignored while the decoder is held disabled
    assign w_valid   = bus.digitos_valid & r_teclado_en;
    assign w_pac     = (r_state == ST_CHECK) ? r_pac : bus.digitos_value;
    assign w_cls     = classifica(w_pac);
    assign w_curto   = (w_qtd < CNT_DIG_W'(MIN_DIGITS));
    assign w_mestre  = (w_pac == MASTER_PW);
    assign w_slot_ok = (w_pac.digits[0] != 4'h0) && (w_pac.digits[0] <= 4'(NUM_USERS));

    conta_digitos u_conta_digitos (
        .i_pac   (w_pac),
        .o_qtd_c (w_qtd)
    );

    // Empty slots never match, so a blank password cannot open the lock
    always_comb begin
        w_match = 1'b0;
        for (int i = 0; i < int'(NUM_USERS); i++) begin
            if ((r_slots[i] != PAC_EMPTY) && (r_slots[i] == r_pac)) w_match = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_tent_nxt     = r_tent;
        w_slot_sel_nxt = r_slot_sel;
        w_wr_en        = 1'b0;
        w_erro_nxt     = 1'b0;
        w_flush        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_valid && (w_cls == CL_DIGITS)) w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                w_flush = 1'b1;
                if (w_curto) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_mestre) begin
                    w_state_nxt = ST_PROG_SLOT;
                    w_tent_nxt  = '0;
                end else if (w_match) begin
                    w_state_nxt = ST_OPEN;
                    w_tent_nxt  = '0;
                end else begin
                    w_erro_nxt = 1'b1;
                    if (r_tent >= TRY_W'(MAX_TRIES - 1)) begin
                        w_tent_nxt  = TRY_W'(MAX_TRIES);
                        w_state_nxt = ST_LOCKOUT;
                    end else begin
                        w_tent_nxt  = r_tent + TRY_W'(1);
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_OPEN: begin
`ifdef FECHADURA_SENSOR_PORTA_EN
                // Timer expiry waits for a closed door; a door closing relocks early
                if (r_fecha_pend) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CNT_W'(UNLOCK_CYC - 1)) begin
                    if (!bus.porta_aberta) w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
`else
                if (r_cnt == CNT_W'(UNLOCK_CYC - 1)) w_state_nxt = ST_IDLE;
                else                                 w_cnt_nxt   = r_cnt + CNT_W'(1);
`endif
            end
            ST_LOCKOUT: begin
                if (r_cnt == CNT_W'(LOCKOUT_CYC - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_tent_nxt  = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_PROG_SLOT: begin
                if (w_valid) begin
                    w_flush = 1'b1;
                    if ((w_cls == CL_DIGITS) && w_slot_ok) begin
                        w_slot_sel_nxt = SLOT_W'(w_pac.digits[0] - 4'd1);
                        w_state_nxt    = ST_PROG_PASS;
                    end else begin
                        w_erro_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_PROG_PASS: begin
                if (w_valid) begin
                    w_flush     = 1'b1;
                    w_state_nxt = ST_IDLE;
                    if ((w_cls == CL_DIGITS) && !w_curto && !w_mestre) w_wr_en    = 1'b1;
                    else                                                w_erro_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_state_nxt != r_state) w_cnt_nxt = '0;

        w_teclado_nxt = !w_flush && (w_state_nxt != ST_OPEN) && (w_state_nxt != ST_LOCKOUT);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_tent       <= '0;
            r_teclado_en <= 1'b1;
            r_tranca     <= 1'b1;
            r_bloqueado  <= 1'b0;
            r_modo_prog  <= 1'b0;
            r_erro       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_tent       <= w_tent_nxt;
            r_teclado_en <= w_teclado_nxt;
            r_tranca     <= (w_state_nxt != ST_OPEN);
            r_bloqueado  <= (w_state_nxt == ST_LOCKOUT);
            r_modo_prog  <= (w_state_nxt == ST_PROG_SLOT) || (w_state_nxt == ST_PROG_PASS);
            r_erro       <= w_erro_nxt;
        end
    end

    // Latched attempt, slot selection and password storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pac      <= PAC_EMPTY;
            r_slot_sel <= '0;
            for (int i = 0; i < int'(NUM_USERS); i++) begin
                r_slots[i] <= (i == 0) ? USER0_PW : PAC_EMPTY;
            end
        end else begin
            r_slot_sel <= w_slot_sel_nxt;
            if ((r_state == ST_IDLE) && w_valid) r_pac <= bus.digitos_value;
            if (w_wr_en) r_slots[r_slot_sel] <= bus.digitos_value;
        end
    end

`ifdef FECHADURA_SENSOR_PORTA_EN
    // Remember the door opened during this unlock; flag the cycle after it closes again
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_porta_vista <= 1'b0;
            r_fecha_pend  <= 1'b0;
        end else begin
            r_porta_vista <= (r_state == ST_OPEN) && (r_porta_vista || bus.porta_aberta);
            r_fecha_pend  <= (r_state == ST_OPEN) && (w_state_nxt == ST_OPEN) &&
                             r_porta_vista && !bus.porta_aberta;
        end
    end
`endif

    assign bus.teclado_en = r_teclado_en;
    assign bus.tranca     = r_tranca;
    assign bus.bloqueado  = r_bloqueado;
    assign bus.modo_prog  = r_modo_prog;
    assign bus.erro       = r_erro;
    assign bus.tentativas = 4'(r_tent);

endmodule

// File: tb/tb_controlador_fechadura.sv
// Scoreboard bench: stimulus queues expected output changes, a monitor pops them as the outputs move.
module tb_controlador_fechadura;
    import fechadura_pkg::*;

    typedef struct packed {
        logic       te;
        logic       tr;
        logic       bl;
        logic       mp;
        logic       er;
        logic [3:0] t;
    } snap_t;

    typedef struct {
        snap_t s;
        int    gap;
        bit    from_mark;
    } exp_t;

    localparam logic [79:0] P_1234 = {{16{4'hF}}, 16'h1234};
    localparam logic [79:0] P_5555 = {{16{4'hF}}, 16'h5555};
    localparam logic [79:0] P_9999 = {{16{4'hF}}, 16'h9999};
    localparam logic [79:0] P_8888 = {{16{4'hF}}, 16'h8888};
    localparam logic [79:0] P_12   = {{18{4'hF}}, 8'h12};
    localparam logic [79:0] P_2    = {{19{4'hF}}, 4'h2};
    localparam logic [79:0] P_5    = {{19{4'hF}}, 4'h5};
    localparam logic [79:0] P_TMO  = {20{4'hE}};
    localparam snap_t RST_SNAP = '{te: 1'b1, tr: 1'b1, bl: 1'b0, mp: 1'b0, er: 1'b0, t: 4'd0};

    logic clk = 1'b0;
    logic rst = 1'b1;

    controlador_fechadura_if bus ();

    controlador_fechadura dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int    n_tests  = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    last_cyc = 0;
    int    mark_cyc = 0;
    bit    mon_en   = 1'b0;
    exp_t  exp_q[$];
    string name_q[$];

    function automatic snap_t snap_now();
        snap_t s;
        s.te = bus.teclado_en;
        s.tr = bus.tranca;
        s.bl = bus.bloqueado;
        s.mp = bus.modo_prog;
        s.er = bus.erro;
        s.t  = bus.tentativas;
        return s;
    endfunction

    task automatic ev(input string nm, input logic te, input logic tr, input logic bl,
                      input logic mp, input logic er, input int t, input int gap, input bit fm);
        exp_t e;
        e.s.te = te; e.s.tr = tr; e.s.bl = bl; e.s.mp = mp; e.s.er = er; e.s.t = 4'(t);
        e.gap = gap;
        e.from_mark = fm;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Failed attempt: erro + count and a 1-cycle keypad flush, two cycles after the strobe
    task automatic exp_fail(input string nm, input int t);
        ev(nm, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, t, 2, 1'b1);
        ev(nm, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, t, 1, 1'b0);
    endtask

    task automatic exp_open(input string nm);
        ev(nm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2, 1'b1);
        ev(nm, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 5000, 1'b0);
    endtask

    task automatic exp_master(input string nm);
        ev(nm, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 2, 1'b1);
        ev(nm, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 1'b0);
    endtask

    task automatic chk(input string nm, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, want);
        end
    endtask

    task automatic send(input logic [79:0] v);
        @(negedge clk);
        bus.digitos_value = senhaPac_t'(v);
        bus.digitos_valid = 1'b1;
        @(negedge clk);
        bus.digitos_valid = 1'b0;
    endtask

    task automatic drain(input string nm, input int budget);
        int i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: %0d events pending after %0d cycles, expected 0",
                     nm, exp_q.size(), budget);
            exp_q.delete();
            name_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    // Cycle of the last accepted-looking strobe, for latency checks
    initial begin : strobe_mark
        forever begin
            @(posedge clk);
            if (bus.digitos_valid) mark_cyc = cyc;
        end
    end

    initial begin : monitor
        snap_t prev, cur;
        exp_t  e;
        string nm;
        int    gap;
        prev = RST_SNAP;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                cur = snap_now();
                if (cur != prev) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_event: got te=%0b tr=%0b bl=%0b mp=%0b er=%0b t=%0d, expected no change",
                                 cur.te, cur.tr, cur.bl, cur.mp, cur.er, cur.t);
                    end else begin
                        e   = exp_q.pop_front();
                        nm  = name_q.pop_front();
                        gap = e.from_mark ? (cyc - mark_cyc) : (cyc - last_cyc);
                        if (cur != e.s || (e.gap >= 0 && gap != e.gap)) begin
                            n_fail++;
                            $display("FAIL %s: got te=%0b tr=%0b bl=%0b mp=%0b er=%0b t=%0d after %0d cyc, expected te=%0b tr=%0b bl=%0b mp=%0b er=%0b t=%0d after %0d cyc",
                                     nm, cur.te, cur.tr, cur.bl, cur.mp, cur.er, cur.t, gap,
                                     e.s.te, e.s.tr, e.s.bl, e.s.mp, e.s.er, e.s.t, e.gap);
                        end
                    end
                    prev     = cur;
                    last_cyc = cyc;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bus.digitos_value = PAC_EMPTY;
        bus.digitos_valid = 1'b0;
`ifdef FECHADURA_SENSOR_PORTA_EN
        bus.porta_aberta  = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_state", int'(snap_now()), int'(RST_SNAP));
        rst    = 1'b0;
        mon_en = 1'b1;

        // User 0 opens; a packet during OPEN is ignored
        exp_open("open_1234");
        send(P_1234);
        repeat (20) @(negedge clk);
        send(P_5555);
        drain("t1", 6000);
        send(P_TMO);
        drain("idle_timeout_ignored", 10);

        // Three failures -> lockout, count saturates, then released
        exp_fail("fail1", 1);
        send(P_5555);
        drain("t2a", 50);
        exp_fail("fail2", 2);
        send(P_5555);
        drain("t2b", 50);
        ev("lockout_in", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3, 2, 1'b1);
        ev("lockout_erro_off", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3, 1, 1'b0);
        ev("lockout_out", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 19999, 1'b0);
        send(P_5555);
        drain("t2c", 21000);

        // Short packet leaves the count alone
        exp_fail("fail_before_short", 1);
        send(P_5555);
        drain("t3a", 50);
        ev("short_flush", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 2, 1'b1);
        ev("short_flush_end", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0);
        send(P_12);
        drain("t3b", 50);

        // Program slot 2 with 8888; both 8888 and 1234 open
        exp_master("master_a");
        send(P_9999);
        drain("t4a", 50);
        ev("slot_sel", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 1'b1);
        ev("slot_sel_end", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 1'b0);
        send(P_2);
        drain("t4b", 50);
        ev("pass_write", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1'b1);
        ev("pass_write_end", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0);
        send(P_8888);
        drain("t4c", 50);
        exp_open("open_8888");
        send(P_8888);
        drain("t4d", 6000);
        exp_open("open_1234_again");
        send(P_1234);
        drain("t4e", 6000);

        // Programming aborts: timeout packet, out-of-range slot digit
        exp_master("master_b");
        send(P_9999);
        drain("t5a", 50);
        ev("prog_timeout", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1, 1'b1);
        ev("prog_timeout_end", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0);
        send(P_TMO);
        drain("t5b", 50);
        exp_master("master_c");
        send(P_9999);
        drain("t5c", 50);
        ev("slot_range", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1, 1'b1);
        ev("slot_range_end", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0);
        send(P_5);
        drain("t5d", 50);
        exp_open("open_8888_kept");
        send(P_8888);
        drain("t5e", 6000);

        // Reset in the middle of lockout
        exp_fail("fail1_b", 1);
        send(P_5555);
        drain("t6a", 50);
        exp_fail("fail2_b", 2);
        send(P_5555);
        drain("t6b", 50);
        ev("lockout_in_b", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3, 2, 1'b1);
        ev("lockout_erro_off_b", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3, 1, 1'b0);
        send(P_5555);
        drain("t6c", 50);
        repeat (100) @(negedge clk);
        ev("reset_release", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, -1, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_bloqueado", int'(bus.bloqueado), 0);
        chk("async_rst_tranca", int'(bus.tranca), 1);
        chk("async_rst_teclado_en", int'(bus.teclado_en), 1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        drain("t6d", 20);
        exp_fail("fail_after_reset", 1);
        send(P_5555);
        drain("t6e", 50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
